// File: rtl/rob_commit_if.sv
// Issue/CDB/query/commit bundle between the reorder buffer (slave) and its surrounding pipeline (master).
// ROB_PERF_CNT_EN adds the perf_commits/perf_flushes counter outputs.
interface rob_commit_if #(parameter int TAG_W = 4);
    logic             alloc_valid;
    logic             alloc_has_rd;
    logic [4:0]       alloc_rd;
    logic             alloc_is_br;
    logic             alloc_pred_taken;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_value;
    logic             wb_br_taken;
    logic [31:0]      wb_br_target;

    logic [TAG_W-1:0] qry1_tag;
    logic             qry1_ready;
    logic [31:0]      qry1_value;
    logic [TAG_W-1:0] qry2_tag;
    logic             qry2_ready;
    logic [31:0]      qry2_value;

    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value;
    logic [TAG_W-1:0] commit_tag;
    logic             rf_cur_busy;
    logic [TAG_W-1:0] rf_cur_tag;
    logic             commit_clear_busy;

    logic             clear_flag;
    logic [31:0]      redirect_pc;

`ifdef ROB_PERF_CNT_EN
    logic [31:0]      perf_commits;
    logic [31:0]      perf_flushes;
`endif

    modport master (
`ifdef ROB_PERF_CNT_EN
        input  perf_commits, perf_flushes,
`endif
        output alloc_valid, alloc_has_rd, alloc_rd, alloc_is_br, alloc_pred_taken,
        input  alloc_ready, alloc_tag,
        output wb_valid, wb_tag, wb_value, wb_br_taken, wb_br_target,
        output qry1_tag, qry2_tag,
        input  qry1_ready, qry1_value, qry2_ready, qry2_value,
        input  commit_valid, commit_rd, commit_value, commit_tag, commit_clear_busy,
        output rf_cur_busy, rf_cur_tag,
        input  clear_flag, redirect_pc
    );

    modport slave (
`ifdef ROB_PERF_CNT_EN
        output perf_commits, perf_flushes,
`endif
        input  alloc_valid, alloc_has_rd, alloc_rd, alloc_is_br, alloc_pred_taken,
        output alloc_ready, alloc_tag,
        input  wb_valid, wb_tag, wb_value, wb_br_taken, wb_br_target,
        input  qry1_tag, qry2_tag,
        output qry1_ready, qry1_value, qry2_ready, qry2_value,
        output commit_valid, commit_rd, commit_value, commit_tag, commit_clear_busy,
        input  rf_cur_busy, rf_cur_tag,
        output clear_flag, redirect_pc
    );
endinterface

// File: rtl/rob_commit.sv
// Circular reorder buffer: tag alloc, CDB capture, operand forwarding, in-order retire, registered 1-cycle flush on mispredict.
// Query/commit outputs are combinational; rdy low freezes all state; optional counters under ROB_PERF_CNT_EN.
module rob_commit #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rdy,
    rob_commit_if.slave  bus
);
    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        has_rd;
        logic [4:0]  rd;
        logic        is_br;
        logic        pred_taken;
        logic        br_taken;
        logic [31:0] value;
        logic [31:0] target;
    } entry_t;

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(ROB_DEPTH);

    entry_t           rob [ROB_DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic             clear_q;
    logic [31:0]      redirect_q;

    entry_t head_e;
    logic   active;
    logic   do_alloc;
    logic   wb_hit;
    logic   commit;
    logic   mispredict;

    assign head_e     = rob[head];
    assign active     = rdy & ~clear_q;
    assign do_alloc   = bus.alloc_valid & bus.alloc_ready;
    assign wb_hit     = bus.wb_valid & active & rob[bus.wb_tag].valid;
    assign commit     = active & (count != '0) & head_e.valid & head_e.ready;
    assign mispredict = commit & head_e.is_br & (head_e.br_taken != head_e.pred_taken);

    assign bus.alloc_ready       = active & (count != FULL);
    assign bus.alloc_tag         = tail;
    assign bus.commit_valid      = commit;
    assign bus.commit_rd         = head_e.has_rd ? head_e.rd : 5'd0;
    assign bus.commit_value      = head_e.value;
    assign bus.commit_tag        = head;
    // An older tag committing must not clear busy if a younger rename now owns the register.
    assign bus.commit_clear_busy = commit & (bus.commit_rd != 5'd0) & bus.rf_cur_busy
                                   & (bus.rf_cur_tag == head);
    assign bus.clear_flag        = clear_q;
    assign bus.redirect_pc       = redirect_q;

    // Returns {ready, value}; the CDB value wins so a consumer sees a result in its writeback cycle.
    function automatic logic [32:0] lookup(input entry_t e, input logic fwd,
                                           input logic [31:0] wv, input logic blk);
        logic r;
        r = ~blk & e.valid & (e.ready | fwd);
        return {r, r ? (fwd ? wv : e.value) : 32'd0};
    endfunction

    assign {bus.qry1_ready, bus.qry1_value} =
        lookup(rob[bus.qry1_tag], bus.wb_valid & (bus.wb_tag == bus.qry1_tag), bus.wb_value, clear_q);
    assign {bus.qry2_ready, bus.qry2_value} =
        lookup(rob[bus.qry2_tag], bus.wb_valid & (bus.wb_tag == bus.qry2_tag), bus.wb_value, clear_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            clear_q    <= 1'b0;
            redirect_q <= 32'd0;
            for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
        end else if (rdy) begin
            if (clear_q) begin
                clear_q <= 1'b0;
            end else if (mispredict) begin
                for (int i = 0; i < ROB_DEPTH; i++) rob[i].valid <= 1'b0;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                clear_q    <= 1'b1;
                redirect_q <= head_e.target;
            end else begin
                if (do_alloc) begin
                    rob[tail] <= '{valid: 1'b1, ready: 1'b0, has_rd: bus.alloc_has_rd,
                                   rd: bus.alloc_rd, is_br: bus.alloc_is_br,
                                   pred_taken: bus.alloc_pred_taken, br_taken: 1'b0,
                                   value: 32'd0, target: 32'd0};
                    tail <= tail + 1'b1;
                end
                if (wb_hit) begin
                    rob[bus.wb_tag].ready    <= 1'b1;
                    rob[bus.wb_tag].value    <= bus.wb_value;
                    rob[bus.wb_tag].br_taken <= bus.wb_br_taken;
                    rob[bus.wb_tag].target   <= bus.wb_br_target;
                end
                // Head and tail slots never coincide when both alloc and commit fire (neither empty nor full).
                if (commit) begin
                    rob[head].valid <= 1'b0;
                    head            <= head + 1'b1;
                end
                case ({do_alloc, commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits_q;
    logic [31:0] perf_flushes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commits_q <= 32'd0;
            perf_flushes_q <= 32'd0;
        end else begin
            if (commit)     perf_commits_q <= perf_commits_q + 32'd1;
            if (mispredict) perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign bus.perf_commits = perf_commits_q;
    assign bus.perf_flushes = perf_flushes_q;
`endif
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Circular reorder buffer that sits between the issue queue and the register/rename file.
- Allocates tags to issued instructions and captures results from the common data bus.
- Supplies operand readiness/forwarding for renamed sources.
- Retires in order, driving the register file's commit-write and busy-clear controls and generating the pipeline-wide clear on branch mispredict.

Parameters:
ROB_DEPTH, 16, number of entries; power of two, minimum 2
TAG_W, 4, tag width; equals log2(ROB_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; low freezes all state
alloc_valid  in  1  issue stage requests an entry
alloc_has_rd  in  1  instruction writes rd
alloc_rd  in  5  destination register index
alloc_is_br  in  1  instruction is a conditional branch
alloc_pred_taken  in  1  predicted direction
alloc_ready  out  1  entry available this cycle
alloc_tag  out  TAG_W  tag assigned (current tail)
wb_valid  in  1  CDB result valid
wb_tag  in  TAG_W  CDB tag
wb_value  in  32  result, or link value for branches
wb_br_taken  in  1  resolved branch direction
wb_br_target  in  32  correct next PC for a mispredicted branch
qry1_tag  in  TAG_W  source-1 tag lookup
qry1_ready  out  1  source-1 value available
qry1_value  out  32  source-1 value
qry2_tag  in  TAG_W  source-2 tag lookup
qry2_ready  out  1  source-2 value available
qry2_value  out  32  source-2 value
commit_valid  out  1  head retires at this edge
commit_rd  out  5  head destination (0 if none)
commit_value  out  32  head result
commit_tag  out  TAG_W  head tag
rf_cur_busy  in  1  register file busy bit for commit_rd
rf_cur_tag  in  TAG_W  register file rename tag for commit_rd
commit_clear_busy  out  1  clear busy bit of commit_rd
clear_flag  out  1  registered one-cycle pipeline flush
redirect_pc  out  32  fetch target while clear_flag is high

Behaviour:
- Reset state: head=tail=0, count=0, all entries invalid, clear_flag=0, redirect_pc=0.
- Per entry: valid, ready, has_rd, rd, is_br, pred_taken, br_taken, value, target.
- alloc_ready = rdy & ~clear_flag & (count != ROB_DEPTH). alloc_tag = tail.
- Allocate when alloc_valid & alloc_ready: write the entry, ready=0, tail+1 mod ROB_DEPTH.
- Full state blocks allocation even if a commit occurs in the same cycle.
- Writeback when wb_valid & rdy & ~clear_flag & entry[wb_tag].valid: set ready, value, br_taken, target. A writeback to an invalid entry is ignored.
- qryN_ready = entry valid & (entry ready | (wb_valid & wb_tag==qryN_tag)). qryN_value = CDB value on a tag match, else the stored value; 0 when not ready. Purely combinational.
- commit_valid = rdy & ~clear_flag & count!=0 & head.ready.
- Head state is combinational; the register file samples it at the same edge.
- A result written back in cycle N commits in cycle N+1 at the earliest.
- commit_rd = head.has_rd ? head.rd : 0.
- commit_clear_busy = commit_valid & commit_rd!=0 & rf_cur_busy & rf_cur_tag==head tag. A younger rename of the same register keeps busy set.
- On commit: head invalidated, head+1 mod ROB_DEPTH.
- count: +1 alloc only, -1 commit only, unchanged when both occur.
- Mispredict: committing branch with br_taken != pred_taken.
  - At that edge: all entries invalidated, head=tail=count=0.
  - Next cycle: clear_flag=1 and redirect_pc=target; cleared after one cycle.
  - A branch with matching prediction commits normally, with no flush.
- During clear_flag: no alloc, no writeback, no commit; qry outputs report not ready.
- rdy low: no state change; commit_valid and alloc_ready are 0; clear_flag holds its value.
- rst_n low mid-operation: immediate return to the reset state, including dropping a pending clear_flag.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_commits[31:0] and perf_flushes[31:0].
  - Both reset to 0 and wrap modulo 2^32.
  - perf_commits increments on each commit_valid; perf_flushes increments on each mispredict commit.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then allocate 3 instructions (rd=5,6,0) -> tags 0,1,2; count=3; alloc_ready=1; commit_valid=0.
- Writeback tag1 value 0xAA, then tag0 value 0x55 -> tag0 commits (rd=5, 0x55) the cycle after its writeback; tag1 commits (rd=6, 0xAA) the next cycle; in-order retirement holds.
- Allocate 16 with no writebacks -> alloc_ready=0 at count=16. Then writeback tag0 and hold alloc_valid -> commit frees a slot; the next alloc gets tag0 (wrap-around).
- qry1_tag=3 while wb_valid, wb_tag=3, wb_value=0x1234 -> qry1_ready=1, qry1_value=0x1234 in the same cycle.
- Rename r7 twice (tags 0,1); commit tag0 with rf_cur_tag=1 -> commit_clear_busy=0. Commit tag1 -> commit_clear_busy=1.
- Branch pred_taken=0, resolved taken with target 0x80 -> on commit, next cycle clear_flag=1 and redirect_pc=0x80 for exactly one cycle; count=0; later allocations start at tag0.
